// File: rtl/axis_framebuffer_reader_if.sv
// Memory read port (AXI4 AR/R) and display stream (AXI-Stream) of the framebuffer reader.
// master: the reader side; slave: the memory / display side.
// Signal names follow the AXI naming used on the reader's external pins.
interface axis_framebuffer_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   m_mem_axi_arid;
  logic [ADDR_WIDTH-1:0] m_mem_axi_araddr;
  logic [7:0]            m_mem_axi_arlen;
  logic [2:0]            m_mem_axi_arsize;
  logic [1:0]            m_mem_axi_arburst;
  logic                  m_mem_axi_arlock;
  logic [3:0]            m_mem_axi_arcache;
  logic [2:0]            m_mem_axi_arprot;
  logic                  m_mem_axi_arvalid;
  logic                  m_mem_axi_arready;

  logic [ID_WIDTH-1:0]   m_mem_axi_rid;
  logic [DATA_WIDTH-1:0] m_mem_axi_rdata;
  logic [1:0]            m_mem_axi_rresp;
  logic                  m_mem_axi_rlast;
  logic                  m_mem_axi_rvalid;
  logic                  m_mem_axi_rready;

  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [STRB_WIDTH-1:0] m_axis_tstrb;

  modport master (
    output m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize,
           m_mem_axi_arburst, m_mem_axi_arlock, m_mem_axi_arcache, m_mem_axi_arprot,
           m_mem_axi_arvalid, m_mem_axi_rready,
           m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb,
    input  m_mem_axi_arready, m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp,
           m_mem_axi_rlast, m_mem_axi_rvalid, m_axis_tready
  );

  modport slave (
    input  m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize,
           m_mem_axi_arburst, m_mem_axi_arlock, m_mem_axi_arcache, m_mem_axi_arprot,
           m_mem_axi_arvalid, m_mem_axi_rready,
           m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb,
    output m_mem_axi_arready, m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp,
           m_mem_axi_rlast, m_mem_axi_rvalid, m_axis_tready
  );
endinterface

// File: rtl/axis_framebuffer_reader.sv
// Reads one framebuffer per start pulse over AXI4 bursts and streams it out on AXI-Stream.
// Latency: at least one cycle from an accepted R beat to the corresponding stream beat.
// Backpressure: bursts are issued only when the beat FIFO has reserved room, so R is never stalled.
module axis_framebuffer_reader #(
  parameter int DATA_WIDTH          = 32,
  parameter int ADDR_WIDTH          = 32,
  parameter int STRB_WIDTH          = 4,
  parameter int ID_WIDTH            = 8,
  parameter int FIFO_DEPTH_LG       = 6,
  parameter int FB_SIZE_IN_PIXEL_LG = 20
) (
  input  logic                           aclk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          fb_addr,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_size,
  output logic                           busy,
  axis_framebuffer_reader_if.master      bus
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_LG;
  localparam int SIZE_LG = $clog2(STRB_WIDTH);
  localparam int CW      = FB_SIZE_IN_PIXEL_LG + 1;
  localparam int RW      = FIFO_DEPTH_LG + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         req_left_q, req_left_d;
  logic [CW-1:0]         beats_q, beats_d;
  logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
  logic [STRB_WIDTH-1:0] last_strb_q, last_strb_d;
  logic [RW-1:0]         reserved_q, reserved_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;

  // Frame geometry from the start request: 2 bytes per pixel, rounded up to whole beats.
  logic [CW:0]           bytes_w;
  logic [CW:0]           beats_sum;
  logic [CW-1:0]         beats_w;
  logic [SIZE_LG-1:0]    rem_w;
  logic [STRB_WIDTH-1:0] strb_w;

  assign bytes_w   = {1'b0, fb_size, 1'b0};
  assign beats_sum = bytes_w + (CW+1)'(STRB_WIDTH - 1);
  assign beats_w   = CW'(beats_sum >> SIZE_LG);
  assign rem_w     = bytes_w[SIZE_LG-1:0];
  assign strb_w    = (rem_w == '0) ? '1 : ((STRB_WIDTH'(1) << rem_w) - STRB_WIDTH'(1));

  // Burst sizing and FIFO credit check for the next AR.
  logic [4:0]    burst_len;
  logic [RW:0]   credit_sum;
  logic          credit_ok;
  logic          ar_hs;
  logic [RW-1:0] ar_beats;

  assign burst_len  = (req_left_q > CW'(16)) ? 5'd16 : req_left_q[4:0];
  assign credit_sum = {1'b0, reserved_q} + (RW+1)'(burst_len);
  assign credit_ok  = credit_sum <= (RW+1)'(DEPTH);
  assign ar_hs      = arvalid_q & bus.m_mem_axi_arready;
  assign ar_beats   = RW'(arlen_q[3:0]) + RW'(1);

  // Beat FIFO between R and the stream.
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [FIFO_DEPTH_LG-1:0] wr_ptr_q, rd_ptr_q;
  logic [RW-1:0]            cnt_q;
  logic                     push, pop, fifo_vld, last_beat;

  assign fifo_vld  = cnt_q != '0;
  assign push      = bus.m_mem_axi_rvalid & busy_q;
  assign pop       = fifo_vld & bus.m_axis_tready;
  assign last_beat = pop_cnt_q == (beats_q - CW'(1));

  // Frame control: start capture, AR issue with credit, completion on the final pop.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    req_left_d  = req_left_q;
    beats_d     = beats_q;
    pop_cnt_d   = pop_cnt_q;
    last_strb_d = last_strb_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    reserved_d  = reserved_q + (ar_hs ? ar_beats : RW'(0)) - (pop ? RW'(1) : RW'(0));
    if (ar_hs) arvalid_d = 1'b0;
    if (pop)   pop_cnt_d = pop_cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        if (start && (fb_size != '0)) begin
          busy_d      = 1'b1;
          state_d     = RUN;
          addr_d      = fb_addr;
          req_left_d  = beats_w;
          beats_d     = beats_w;
          last_strb_d = strb_w;
          pop_cnt_d   = '0;
        end
      end
      RUN: begin
        if (!arvalid_q) begin
          if (req_left_q == '0) begin
            state_d = DRAIN;
          end else if (credit_ok) begin
            arvalid_d  = 1'b1;
            araddr_d   = addr_q;
            arlen_d    = {3'b000, burst_len - 5'd1};
            addr_d     = addr_q + (ADDR_WIDTH'(burst_len) << SIZE_LG);
            req_left_d = req_left_q - CW'(burst_len);
          end
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase
    if (busy_q && pop && last_beat) begin
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  // Control registers.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      req_left_q  <= '0;
      beats_q     <= '0;
      pop_cnt_q   <= '0;
      last_strb_q <= '0;
      reserved_q  <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      req_left_q  <= req_left_d;
      beats_q     <= beats_d;
      pop_cnt_q   <= pop_cnt_d;
      last_strb_q <= last_strb_d;
      reserved_q  <= reserved_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
    end
  end

  // FIFO pointers and occupancy; a push into a full FIFO means the credit scheme broke.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) assert (cnt_q != RW'(DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + RW'(1);
        2'b01:   cnt_q <= cnt_q - RW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage, written in R arrival order.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= bus.m_mem_axi_rdata;
  end

  // Response id/status/last carry no information for a single in-order read stream.
  logic unused_r;
  assign unused_r = ^{bus.m_mem_axi_rid, bus.m_mem_axi_rresp, bus.m_mem_axi_rlast};

  assign busy                  = busy_q;
  assign bus.m_mem_axi_arid    = {ID_WIDTH{1'b0}};
  assign bus.m_mem_axi_araddr  = araddr_q;
  assign bus.m_mem_axi_arlen   = arlen_q;
  assign bus.m_mem_axi_arsize  = 3'(SIZE_LG);
  assign bus.m_mem_axi_arburst = 2'b01;
  assign bus.m_mem_axi_arlock  = 1'b0;
  assign bus.m_mem_axi_arcache = 4'b0011;
  assign bus.m_mem_axi_arprot  = 3'b000;
  assign bus.m_mem_axi_arvalid = arvalid_q;
  assign bus.m_mem_axi_rready  = busy_q;
  assign bus.m_axis_tvalid     = fifo_vld;
  assign bus.m_axis_tdata      = mem_q[rd_ptr_q];
  assign bus.m_axis_tlast      = fifo_vld & last_beat;
  assign bus.m_axis_tstrb      = last_beat ? last_strb_q : '1;

endmodule

// File: tb/tb_axis_framebuffer_reader.sv
// Directed bench for axis_framebuffer_reader: memory model returns beat address ^ PAT,
// one beat per cycle; stream beats and AR requests are logged and checked per scenario.
module tb_axis_framebuffer_reader;
  localparam int DW = 32, AW = 32, SW = 4, IW = 8, LG = 6, FBW = 20;
  localparam logic [31:0] PAT = 32'h5A5A_0000;

  logic           aclk    = 1'b0;
  logic           resetn  = 1'b0;
  logic           start   = 1'b0;
  logic [AW-1:0]  fb_addr = '0;
  logic [FBW-1:0] fb_size = '0;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0]   ar_addr_log [256];
  logic [7:0]    ar_len_log  [256];
  int            ar_cnt = 0;
  int            r_taken = 0;
  logic [31:0]   obs_data [1024];
  logic [SW-1:0] obs_strb [1024];
  logic          obs_last [1024];
  int            obs_cyc  [1024];
  int            obs_cnt = 0;

  int          cur_left = 0;
  logic [31:0] cur_addr = '0;
  int          ar_rd = 0;
  int          r_seen = 0;

  axis_framebuffer_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) bus ();

  axis_framebuffer_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
    .FIFO_DEPTH_LG(LG), .FB_SIZE_IN_PIXEL_LG(FBW)
  ) dut (
    .aclk(aclk), .resetn(resetn), .start(start), .fb_addr(fb_addr),
    .fb_size(fb_size), .busy(busy), .bus(bus)
  );

  always #5 aclk = ~aclk;

  // Log handshakes as sampled at each rising edge.
  always @(posedge aclk) begin
    if (resetn) begin
      if (bus.m_mem_axi_arvalid && bus.m_mem_axi_arready) begin
        ar_addr_log[ar_cnt % 256] = bus.m_mem_axi_araddr;
        ar_len_log[ar_cnt % 256]  = bus.m_mem_axi_arlen;
        ar_cnt = ar_cnt + 1;
      end
      if (bus.m_mem_axi_rvalid && bus.m_mem_axi_rready) r_taken = r_taken + 1;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        obs_data[obs_cnt % 1024] = bus.m_axis_tdata;
        obs_strb[obs_cnt % 1024] = bus.m_axis_tstrb;
        obs_last[obs_cnt % 1024] = bus.m_axis_tlast;
        obs_cyc[obs_cnt % 1024]  = cyc;
        obs_cnt = obs_cnt + 1;
      end
    end
    cyc = cyc + 1;
  end

  // Memory model: serves logged ARs in order, one R beat per cycle.
  always @(negedge aclk) begin
    bus.m_mem_axi_rid   = '0;
    bus.m_mem_axi_rresp = 2'b00;
    if (!resetn) begin
      cur_left = 0;
      ar_rd    = ar_cnt;
      r_seen   = r_taken;
      bus.m_mem_axi_rvalid = 1'b0;
      bus.m_mem_axi_rdata  = '0;
      bus.m_mem_axi_rlast  = 1'b0;
    end else begin
      if (r_taken != r_seen) begin
        r_seen   = r_taken;
        cur_left = cur_left - 1;
        cur_addr = cur_addr + 32'd4;
      end
      if (cur_left == 0 && ar_rd != ar_cnt) begin
        cur_addr = ar_addr_log[ar_rd % 256];
        cur_left = int'(ar_len_log[ar_rd % 256]) + 1;
        ar_rd    = ar_rd + 1;
      end
      bus.m_mem_axi_rvalid = (cur_left != 0);
      bus.m_mem_axi_rdata  = cur_addr ^ PAT;
      bus.m_mem_axi_rlast  = (cur_left == 1);
    end
  end

  // Called at a falling edge; start is seen at the next rising edge.
  task automatic start_frame(input logic [31:0] addr, input int size);
    fb_addr = addr;
    fb_size = FBW'(size);
    start   = 1'b1;
    @(negedge aclk);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int fall_cyc, output bit tmo);
    tmo = 1'b1;
    fall_cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) begin
        fall_cyc = cyc;
        tmo = 1'b0;
        break;
      end
      @(negedge aclk);
    end
  endtask

  task automatic test_reset;
    bus.m_mem_axi_arready = 1'b1;
    bus.m_axis_tready     = 1'b1;
    resetn = 1'b0;
    repeat (3) @(negedge aclk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (bus.m_mem_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", bus.m_mem_axi_arvalid); end
    n_checks++; if (bus.m_mem_axi_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b want 0", bus.m_mem_axi_rready); end
    n_checks++; if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", bus.m_axis_tvalid); end
    n_checks++; if (bus.m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", bus.m_axis_tlast); end
    n_checks++;
    if (bus.m_mem_axi_arid !== 8'h00 || bus.m_mem_axi_arsize !== 3'd2 || bus.m_mem_axi_arburst !== 2'b01 ||
        bus.m_mem_axi_arlock !== 1'b0 || bus.m_mem_axi_arcache !== 4'b0011 || bus.m_mem_axi_arprot !== 3'b000) begin
      n_fail++;
      $display("FAIL ar_constants: got id=%h size=%0d burst=%b lock=%b cache=%b prot=%b want 00/2/01/0/0011/000",
               bus.m_mem_axi_arid, bus.m_mem_axi_arsize, bus.m_mem_axi_arburst, bus.m_mem_axi_arlock,
               bus.m_mem_axi_arcache, bus.m_mem_axi_arprot);
    end
    resetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_basic;
    int ab, ob, fc, idx;
    bit tmo;
    ab = ar_cnt; ob = obs_cnt;
    start_frame(32'h1000, 64);
    wait_idle(1000, fc, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL basic_timeout: busy still %b want 0", busy); end
    n_checks++; if (ar_cnt - ab !== 2) begin n_fail++; $display("FAIL basic_ar_count: got %0d want 2", ar_cnt - ab); end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ar_addr_log[(ab+k)%256] !== 32'h1000 + 32'h40*k || ar_len_log[(ab+k)%256] !== 8'd15) begin
        n_fail++;
        $display("FAIL basic_ar%0d: got %h/%0d want %h/15", k, ar_addr_log[(ab+k)%256], ar_len_log[(ab+k)%256], 32'h1000 + 32'h40*k);
      end
    end
    n_checks++; if (obs_cnt - ob !== 32) begin n_fail++; $display("FAIL basic_beats: got %0d want 32", obs_cnt - ob); end
    for (int i = 0; i < 32; i++) begin
      idx = (ob + i) % 1024;
      n_checks++;
      if (obs_data[idx] !== ((32'h1000 + 32'd4*i) ^ PAT) || obs_strb[idx] !== 4'hF || obs_last[idx] !== (i == 31)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got %h/%b/%b want %h/1111/%b", i, obs_data[idx], obs_strb[idx], obs_last[idx],
                 (32'h1000 + 32'd4*i) ^ PAT, (i == 31));
      end
    end
    n_checks++;
    if (fc !== obs_cyc[(ob+31)%1024] + 1) begin
      n_fail++; $display("FAIL basic_busy_fall: got cycle %0d want %0d", fc, obs_cyc[(ob+31)%1024] + 1);
    end
  endtask

  // Starts at the very falling edge where busy first reads 0.
  task automatic test_back_to_back_tail;
    int ab, ob, fc, idx;
    bit tmo;
    ab = ar_cnt; ob = obs_cnt;
    start_frame(32'h8000, 40);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tail_busy_set: got %b want 1", busy); end
    wait_idle(1000, fc, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL tail_timeout: busy still %b want 0", busy); end
    n_checks++; if (ar_cnt - ab !== 2) begin n_fail++; $display("FAIL tail_ar_count: got %0d want 2", ar_cnt - ab); end
    n_checks++;
    if (ar_addr_log[ab%256] !== 32'h8000 || ar_len_log[ab%256] !== 8'd15 ||
        ar_addr_log[(ab+1)%256] !== 32'h8040 || ar_len_log[(ab+1)%256] !== 8'd3) begin
      n_fail++;
      $display("FAIL tail_ars: got %h/%0d %h/%0d want 00008000/15 00008040/3", ar_addr_log[ab%256], ar_len_log[ab%256],
               ar_addr_log[(ab+1)%256], ar_len_log[(ab+1)%256]);
    end
    n_checks++; if (obs_cnt - ob !== 20) begin n_fail++; $display("FAIL tail_beats: got %0d want 20", obs_cnt - ob); end
    for (int i = 0; i < 20; i++) begin
      idx = (ob + i) % 1024;
      n_checks++;
      if (obs_data[idx] !== ((32'h8000 + 32'd4*i) ^ PAT) || obs_strb[idx] !== 4'hF || obs_last[idx] !== (i == 19)) begin
        n_fail++;
        $display("FAIL tail_beat%0d: got %h/%b/%b want %h/1111/%b", i, obs_data[idx], obs_strb[idx], obs_last[idx],
                 (32'h8000 + 32'd4*i) ^ PAT, (i == 19));
      end
    end
  endtask

  task automatic test_small;
    int ab, ob, fc;
    bit tmo;
    ab = ar_cnt; ob = obs_cnt;
    start_frame(32'h2000, 3);
    wait_idle(500, fc, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL small_timeout: busy still %b want 0", busy); end
    n_checks++;
    if (ar_cnt - ab !== 1 || ar_addr_log[ab%256] !== 32'h2000 || ar_len_log[ab%256] !== 8'd1) begin
      n_fail++;
      $display("FAIL small_ar: got n=%0d %h/%0d want 1 00002000/1", ar_cnt - ab, ar_addr_log[ab%256], ar_len_log[ab%256]);
    end
    n_checks++; if (obs_cnt - ob !== 2) begin n_fail++; $display("FAIL small_beats: got %0d want 2", obs_cnt - ob); end
    n_checks++;
    if (obs_data[ob%1024] !== (32'h2000 ^ PAT) || obs_strb[ob%1024] !== 4'hF || obs_last[ob%1024] !== 1'b0) begin
      n_fail++;
      $display("FAIL small_beat0: got %h/%b/%b want %h/1111/0", obs_data[ob%1024], obs_strb[ob%1024], obs_last[ob%1024], 32'h2000 ^ PAT);
    end
    n_checks++;
    if (obs_data[(ob+1)%1024] !== (32'h2004 ^ PAT) || obs_strb[(ob+1)%1024] !== 4'b0011 || obs_last[(ob+1)%1024] !== 1'b1) begin
      n_fail++;
      $display("FAIL small_beat1: got %h/%b/%b want %h/0011/1", obs_data[(ob+1)%1024], obs_strb[(ob+1)%1024],
               obs_last[(ob+1)%1024], 32'h2004 ^ PAT);
    end
  endtask

  task automatic test_credit;
    int ab, ob, rb, fc, idx;
    bit tmo;
    ab = ar_cnt; ob = obs_cnt; rb = r_taken;
    bus.m_axis_tready = 1'b0;
    start_frame(32'h0001_0000, 256);
    repeat (150) @(negedge aclk);
    n_checks++; if (ar_cnt - ab !== 4) begin n_fail++; $display("FAIL credit_ar_held: got %0d want 4", ar_cnt - ab); end
    n_checks++; if (bus.m_mem_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL credit_arvalid: got %b want 0", bus.m_mem_axi_arvalid); end
    n_checks++; if (r_taken - rb !== 64) begin n_fail++; $display("FAIL credit_fifo_fill: got %0d want 64", r_taken - rb); end
    n_checks++; if (bus.m_mem_axi_rready !== 1'b1) begin n_fail++; $display("FAIL credit_rready: got %b want 1", bus.m_mem_axi_rready); end
    n_checks++;
    if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== (32'h0001_0000 ^ PAT)) begin
      n_fail++; $display("FAIL credit_head: got %b/%h want 1/%h", bus.m_axis_tvalid, bus.m_axis_tdata, 32'h0001_0000 ^ PAT);
    end
    bus.m_axis_tready = 1'b1;
    wait_idle(3000, fc, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL credit_timeout: busy still %b want 0", busy); end
    n_checks++; if (ar_cnt - ab !== 8) begin n_fail++; $display("FAIL credit_ar_count: got %0d want 8", ar_cnt - ab); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (ar_addr_log[(ab+k)%256] !== 32'h0001_0000 + 32'h40*k || ar_len_log[(ab+k)%256] !== 8'd15) begin
        n_fail++;
        $display("FAIL credit_ar%0d: got %h/%0d want %h/15", k, ar_addr_log[(ab+k)%256], ar_len_log[(ab+k)%256], 32'h0001_0000 + 32'h40*k);
      end
    end
    n_checks++; if (obs_cnt - ob !== 128) begin n_fail++; $display("FAIL credit_beats: got %0d want 128", obs_cnt - ob); end
    for (int i = 0; i < 128; i++) begin
      idx = (ob + i) % 1024;
      n_checks++;
      if (obs_data[idx] !== ((32'h0001_0000 + 32'd4*i) ^ PAT) || obs_strb[idx] !== 4'hF || obs_last[idx] !== (i == 127)) begin
        n_fail++;
        $display("FAIL credit_beat%0d: got %h/%b/%b want %h/1111/%b", i, obs_data[idx], obs_strb[idx], obs_last[idx],
                 (32'h0001_0000 + 32'd4*i) ^ PAT, (i == 127));
      end
    end
  endtask

  task automatic test_ignore;
    int ab, ob, fc;
    bit tmo;
    ab = ar_cnt;
    start_frame(32'h5000, 0);
    repeat (5) @(negedge aclk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_size_busy: got %b want 0", busy); end
    n_checks++; if (ar_cnt - ab !== 0) begin n_fail++; $display("FAIL zero_size_ar: got %0d want 0", ar_cnt - ab); end
    ab = ar_cnt; ob = obs_cnt;
    start_frame(32'h6000, 64);
    repeat (3) @(negedge aclk);
    start_frame(32'h9000, 16);
    wait_idle(1000, fc, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL busy_start_timeout: busy still %b want 0", busy); end
    repeat (5) @(negedge aclk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_late: got busy %b want 0", busy); end
    n_checks++;
    if (ar_cnt - ab !== 2 || ar_addr_log[ab%256] !== 32'h6000 || ar_addr_log[(ab+1)%256] !== 32'h6040) begin
      n_fail++;
      $display("FAIL busy_start_ar: got n=%0d %h %h want 2 00006000 00006040", ar_cnt - ab, ar_addr_log[ab%256], ar_addr_log[(ab+1)%256]);
    end
    n_checks++;
    if (obs_cnt - ob !== 32 || obs_data[(ob+31)%1024] !== ((32'h6000 + 32'd124) ^ PAT) || obs_last[(ob+31)%1024] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_stream: got n=%0d last=%h/%b want 32 %h/1", obs_cnt - ob, obs_data[(ob+31)%1024],
               obs_last[(ob+31)%1024], (32'h6000 + 32'd124) ^ PAT);
    end
  endtask

  task automatic test_reset_midframe;
    int ab, ob, fc, idx;
    bit tmo, got10;
    ob = obs_cnt;
    start_frame(32'h3000, 64);
    got10 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (obs_cnt - ob >= 10) begin got10 = 1'b1; break; end
      @(negedge aclk);
    end
    n_checks++; if (!got10) begin n_fail++; $display("FAIL midreset_reach10: got %0d beats want 10", obs_cnt - ob); end
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.m_mem_axi_arvalid !== 1'b0 || bus.m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear: got busy=%b arvalid=%b tvalid=%b want 0/0/0", busy, bus.m_mem_axi_arvalid, bus.m_axis_tvalid);
    end
    repeat (3) @(negedge aclk);
    resetn = 1'b1;
    ab = ar_cnt; ob = obs_cnt;
    start_frame(32'h4000, 64);
    wait_idle(1000, fc, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL postreset_timeout: busy still %b want 0", busy); end
    n_checks++;
    if (ar_cnt - ab !== 2 || ar_addr_log[ab%256] !== 32'h4000 || ar_addr_log[(ab+1)%256] !== 32'h4040) begin
      n_fail++;
      $display("FAIL postreset_ar: got n=%0d %h %h want 2 00004000 00004040", ar_cnt - ab, ar_addr_log[ab%256], ar_addr_log[(ab+1)%256]);
    end
    n_checks++; if (obs_cnt - ob !== 32) begin n_fail++; $display("FAIL postreset_beats: got %0d want 32", obs_cnt - ob); end
    for (int i = 0; i < 32; i++) begin
      idx = (ob + i) % 1024;
      n_checks++;
      if (obs_data[idx] !== ((32'h4000 + 32'd4*i) ^ PAT) || obs_last[idx] !== (i == 31)) begin
        n_fail++;
        $display("FAIL postreset_beat%0d: got %h/%b want %h/%b", i, obs_data[idx], obs_last[idx], (32'h4000 + 32'd4*i) ^ PAT, (i == 31));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_tail();
    test_small();
    test_credit();
    test_ignore();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_framebuffer_reader.md
Name: axis_framebuffer_reader

Overview:
Downstream counterpart of the framebuffer writer. It reads a committed framebuffer (16-bit pixels) from memory over an AXI4 read port and emits it as an AXI-Stream toward the display. Read bursts are credit-limited by an internal beat FIFO, so AXI R data is never stalled by display backpressure beyond FIFO capacity. One frame is read per start pulse.

Parameters:
DATA_WIDTH, 32, width of the AXI R data and stream tdata in bits (multiple of 16)
ADDR_WIDTH, 32, AXI address width
STRB_WIDTH, 4, DATA_WIDTH/8
ID_WIDTH, 8, AXI ID width; arid is driven as 0
FIFO_DEPTH_LG, 6, log2 of beat FIFO depth (minimum 4, i.e. one 16-beat burst)
FB_SIZE_IN_PIXEL_LG, 20, width of fb_size

Ports:
aclk  in  1  clock
resetn  in  1  reset; asynchronous assert, active-low
start  in  1  pulse: begin reading one frame
fb_addr  in  ADDR_WIDTH  frame base address, aligned to 16*STRB_WIDTH bytes
fb_size  in  FB_SIZE_IN_PIXEL_LG  frame size in pixels
busy  out  1  high from accepted start until the last stream beat is accepted
m_axis_tvalid/tready/tlast  out/in/out  1 each  display stream handshake
m_axis_tdata  out  DATA_WIDTH  pixel data, unchanged from memory
m_axis_tstrb  out  STRB_WIDTH  valid bytes; all ones except on the final beat
m_mem_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  AR channel
m_mem_axi_arvalid/arready  out/in  1  AR handshake
m_mem_axi_rid/rdata/rresp/rlast  in  ID_WIDTH/DATA_WIDTH/2/1  R channel
m_mem_axi_rvalid/rready  in/out  1  R handshake

Behaviour:
- Reset values: busy=0, arvalid=0, rready=0, m_axis_tvalid=0, tlast=0, FIFO empty, all counters 0. Constant outputs: arid=0, arsize=log2(STRB_WIDTH), arburst=INCR (01), arlock=0, arcache=0011, arprot=000.
- Bytes = 2*fb_size. Beats = ceil(Bytes/STRB_WIDTH). Final-beat tstrb has the low (Bytes mod STRB_WIDTH) bits set, or all ones if the remainder is 0.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 with fb_size!=0 latches addr, Beats, and final tstrb; sets busy=1; goes to RUN the next cycle. start with fb_size=0 is ignored (busy stays 0). start while busy is ignored.
- RUN, AR issue: burst length L = min(16, remaining beats to request); arlen = L-1. A burst is presented only if reserved+L <= 2^FIFO_DEPTH_LG. reserved increments by L on the AR handshake and decrements by 1 on each stream beat pop. araddr advances by L*STRB_WIDTH per burst. arvalid/araddr/arlen are held stable until arready. Once all beats are requested, go to DRAIN.
- R channel: rready=1 whenever busy. The credit scheme guarantees FIFO space, so a push on a full FIFO is an assertion failure. rresp, rid, and rlast are ignored for data flow. Beats are pushed in arrival order.
- Stream: tvalid = FIFO not empty (registered FIFO output, ≥1 cycle latency from R to stream). A beat pops on tvalid&&tready. tlast and the reduced tstrb apply only to beat number Beats. tdata/tstrb/tlast are held stable while tvalid&&!tready.
- DRAIN: busy drops on the cycle after the final beat's handshake; return to IDLE. A new start is accepted the cycle busy reads 0.
- Simultaneous FIFO push and pop: both occur; occupancy is unchanged.
- Asynchronous reset mid-frame: all state clears immediately and in-flight AXI responses are discarded. The interconnect is reset together with this block.
- Counters: beat counters are FB_SIZE_IN_PIXEL_LG+1 bits wide; reserved is FIFO_DEPTH_LG+1 bits wide.

Test Plan:
- fb_addr=0x1000, fb_size=64, tready=1, memory returns 1 beat/cycle -> ARs (0x1000, arlen 15) and (0x1040, arlen 15); 32 stream beats with data in order; tlast only on beat 32 with tstrb=1111; busy falls one cycle later.
- fb_size=40 -> 20 beats; bursts arlen 15 then arlen 3 at +0x40; tlast on beat 20.
- fb_size=3 -> 2 beats; single AR with arlen=1; final beat tstrb=0011, tlast=1.
- fb_size=256, tready=0 -> exactly 4 ARs issued (64 beats reserved); 5th AR withheld; rready stays 1 and FIFO holds 64 beats. Raising tready lets the remaining 4 bursts issue, and all 128 beats arrive in order.
- start during busy, and start with fb_size=0 -> no AR issued, busy unaffected.
- resetn low at beat 10 of a 32-beat frame -> busy, arvalid, and tvalid are 0 immediately; a fresh start after reset reads the full frame correctly.
